key_scan_ctrl: RTL and testbench

- Sequencer for the 4-row x 5-column matrix keypad feeding the board's anti-jitter and input stage.
- Drives column strobes Key_x and samples the row returns Key_y.
- Debounces press and release, then encodes a single key code.
- Presents the code to the CPU/display side through a Key_ready / readn handshake, with overrun detection.

---
 rtl/key_scan_ctrl.sv | 174 +++++++++++++++++
 tb/tb_key_scan_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/key_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : key_scan_ctrl
// Description : 4x5 matrix keypad scanner with press/release debounce, key
//               encoding and a ready/readn handshake with overrun flag.
// Revision    : 1.0 - initial release
// ============================================================================
module key_scan_ctrl #(
    parameter logic [15:0] SCAN_DIV = 16'd50000,
    parameter logic [3:0]  DEB_CNT  = 4'd4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] Key_y,
    input  logic       readn,
    output logic [4:0] Key_x,
    output logic [4:0] Key_out,
    output logic       Key_ready,
    output logic       overrun,
    output logic       key_busy
);

    localparam logic [1:0] c_ST_SCAN     = 2'd0;
    localparam logic [1:0] c_ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] c_ST_HELD     = 2'd2;
    localparam logic [1:0] c_ST_RELEASE  = 2'd3;
    localparam logic [2:0] c_LAST_COL    = 3'd4;

    logic [3:0]  r_ys_meta;
    logic [3:0]  r_ys;
    logic [15:0] r_div;
    logic [2:0]  r_col;
    logic [1:0]  r_row;
    logic [3:0]  r_deb;
    logic [1:0]  r_state;
    logic [4:0]  r_key_out;
    logic        r_ready;
    logic        r_overrun;

    logic        w_sample;
    logic        w_all_high;
    logic        w_row_low;
    logic [1:0]  w_row;
    logic [2:0]  w_col_next;
    logic [3:0]  w_deb_inc;
    logic        w_emit;
    logic [4:0]  w_emit_code;

    // Row returns are asynchronous to clk; every decision uses r_ys only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ys_meta <= 4'b1111;
            r_ys      <= 4'b1111;
        end else begin
            r_ys_meta <= Key_y;
            r_ys      <= r_ys_meta;
        end
    end

    assign w_sample   = (r_div == SCAN_DIV - 16'd1);
    assign w_all_high = (r_ys == 4'b1111);
    assign w_row_low  = ~r_ys[r_row];
    assign w_col_next = (r_col == c_LAST_COL) ? 3'd0 : r_col + 3'd1;
    assign w_deb_inc  = r_deb + 4'd1;

    // Lowest-index active row wins when several rows are low together.
    always_comb begin
        w_row = 2'd3;
        if (!r_ys[0])      w_row = 2'd0;
        else if (!r_ys[1]) w_row = 2'd1;
        else if (!r_ys[2]) w_row = 2'd2;
    end

    always_comb begin
        w_emit      = 1'b0;
        w_emit_code = {r_col, 2'b00} + {3'b000, r_row};
        if (w_sample) begin
            if (r_state == c_ST_SCAN) begin
                w_emit      = !w_all_high && (DEB_CNT == 4'd1);
                w_emit_code = {r_col, 2'b00} + {3'b000, w_row};
            end else if (r_state == c_ST_DEBOUNCE) begin
                w_emit      = w_row_low && (w_deb_inc >= DEB_CNT);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div   <= 16'd0;
            r_col   <= 3'd0;
            r_row   <= 2'd0;
            r_deb   <= 4'd0;
            r_state <= c_ST_SCAN;
        end else begin
            r_div <= w_sample ? 16'd0 : r_div + 16'd1;
            if (w_sample) begin
                case (r_state)
                    c_ST_SCAN: begin
                        if (w_all_high) begin
                            r_col <= w_col_next;
                        end else begin
                            r_row   <= w_row;
                            r_deb   <= 4'd1;
                            r_state <= (DEB_CNT == 4'd1) ? c_ST_HELD : c_ST_DEBOUNCE;
                        end
                    end
                    c_ST_DEBOUNCE: begin
                        // Only the latched row counts; other rows are ignored.
                        if (w_row_low) begin
                            r_deb <= w_deb_inc;
                            if (w_deb_inc >= DEB_CNT) r_state <= c_ST_HELD;
                        end else begin
                            r_deb   <= 4'd0;
                            r_col   <= w_col_next;
                            r_state <= c_ST_SCAN;
                        end
                    end
                    c_ST_HELD: begin
                        if (w_all_high) begin
                            if (DEB_CNT == 4'd1) begin
                                r_deb   <= 4'd0;
                                r_col   <= w_col_next;
                                r_state <= c_ST_SCAN;
                            end else begin
                                r_deb   <= 4'd1;
                                r_state <= c_ST_RELEASE;
                            end
                        end
                    end
                    c_ST_RELEASE: begin
                        if (w_all_high) begin
                            if (w_deb_inc >= DEB_CNT) begin
                                r_deb   <= 4'd0;
                                r_col   <= w_col_next;
                                r_state <= c_ST_SCAN;
                            end else begin
                                r_deb <= w_deb_inc;
                            end
                        end else begin
                            r_deb   <= DEB_CNT;
                            r_state <= c_ST_HELD;
                        end
                    end
                    default: r_state <= c_ST_SCAN;
                endcase
            end
        end
    end

    // An emit on the same edge as a read takes priority; the read still
    // consumes the old code, so overrun is only set when nobody read it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key_out <= 5'd0;
            r_ready   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (w_emit) begin
            r_key_out <= w_emit_code;
            r_ready   <= 1'b1;
            if (r_ready) r_overrun <= readn;
        end else if (r_ready && !readn) begin
            r_ready   <= 1'b0;
            r_overrun <= 1'b0;
        end
    end

    assign Key_x     = ~(5'b00001 << r_col);
    assign Key_out   = r_key_out;
    assign Key_ready = r_ready;
    assign overrun   = r_overrun;
    assign key_busy  = (r_state != c_ST_SCAN);

endmodule
`default_nettype wire

// File: tb/tb_key_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_scan_ctrl
// Description : Self-checking bench for key_scan_ctrl with a keypad model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_scan_ctrl;

    localparam int DIV = 4;
    localparam int DEB = 3;

    typedef struct {
        int         c;
        logic [3:0] mask;
        bit         rd_first;
        bit         rd_emit;
        bit         glitch;
        int         exp_code;
        bit         exp_over;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       readn = 1'b1;
    logic [3:0] key_y;
    logic [4:0] key_x;
    logic [4:0] key_out;
    logic       key_ready;
    logic       overrun;
    logic       key_busy;
    logic [3:0] pressed [5];

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int t0, c0, m_code;
    bit m_ready, m_over;
    vec_t vt [8];

    key_scan_ctrl #(.SCAN_DIV(16'd4), .DEB_CNT(4'd3)) dut (
        .clk       (clk),
        .rst       (rst),
        .Key_y     (key_y),
        .readn     (readn),
        .Key_x     (key_x),
        .Key_out   (key_out),
        .Key_ready (key_ready),
        .overrun   (overrun),
        .key_busy  (key_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Physical keypad: a pressed key shorts its row low while its column drives low.
    always_comb begin
        key_y = 4'b1111;
        for (int c = 0; c < 5; c++)
            if (!key_x[c]) key_y = key_y & ~pressed[c];
    end

    function automatic logic [4:0] colpat(int c);
        logic [4:0] v;
        v = 5'b00001 << c;
        return ~v;
    endfunction

    function automatic int ref_code(int c, logic [3:0] m);
        for (int r = 0; r < 4; r++)
            if (m[r]) return c * 4 + r;
        return -1;
    endfunction

    // First sample edge on the lattice base+DIV*k that sees a level applied at
    // cycle p (two synchroniser edges), restricted to dwells of column c if c>=0.
    function automatic int first_sample(int base, int col0, int c, int p);
        for (int k = 1; k < 100; k++)
            if ((c < 0 || (col0 + k - 1) % 5 == c) && base + DIV * k >= p + 3)
                return base + DIV * k;
        return base + DIV * 100;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step_to(int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic chk_reset_vals(string tag);
        chk({tag, "_key_x"}, key_x, 5'b11110);
        chk({tag, "_ready"}, key_ready, 0);
        chk({tag, "_key_out"}, key_out, 0);
        chk({tag, "_overrun"}, overrun, 0);
        chk({tag, "_busy"}, key_busy, 0);
    endtask

    task automatic do_key(int c, logic [3:0] mask, bit rd_first, bit rd_emit,
                          bit glitch, int hold, int exp_code, bit exp_over);
        int p, s, e, r, s1, ts;
        if (rd_first) begin
            readn = 1'b0;
            @(negedge clk);
            readn = 1'b1;
            chk("read_clears_ready", key_ready, 0);
            chk("read_clears_overrun", overrun, 0);
            chk("read_keeps_code", key_out, m_code);
            m_ready = 1'b0;
            m_over  = 1'b0;
        end
        pressed[c] = mask;
        p = cyc;
        s = first_sample(t0, c0, c, p);
        e = s + DIV * (DEB - 1);
        step_to(e - 1);
        chk("ready_before_emit", key_ready, m_ready);
        if (rd_emit) readn = 1'b0;
        @(negedge clk);
        readn = 1'b1;
        chk("emit_ready", key_ready, 1);
        chk("emit_code", key_out, exp_code);
        chk("emit_overrun", overrun, exp_over);
        m_ready = 1'b1;
        m_over  = exp_over;
        m_code  = exp_code;
        step_to(e + hold);
        chk("held_column_frozen", key_x, colpat(c));
        chk("held_no_reemit", overrun, m_over);
        pressed[c] = 4'b0000;
        r  = cyc;
        s1 = first_sample(e, 0, -1, r);
        if (glitch) begin
            step_to(s1);
            pressed[c] = mask;
            step_to(s1 + DIV + 1);
            chk("glitch_still_busy", key_busy, 1);
            chk("glitch_no_reemit", overrun, m_over);
            pressed[c] = 4'b0000;
            r  = cyc;
            s1 = first_sample(e, 0, -1, r);
        end
        ts = s1 + DIV * (DEB - 1);
        step_to(ts - 1);
        chk("busy_before_rescan", key_busy, 1);
        @(negedge clk);
        chk("busy_after_rescan", key_busy, 0);
        chk("rescan_column", key_x, colpat((c + 1) % 5));
        t0 = ts;
        c0 = (c + 1) % 5;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int s, c, hold, exp_code;
        logic [3:0] mask;
        bit rf, re, rp, op, exp_over;

        for (int i = 0; i < 5; i++) pressed[i] = 4'b0000;
        vt[0] = '{2, 4'b0010, 1'b0, 1'b0, 1'b0,  9, 1'b0};
        vt[1] = '{4, 4'b1000, 1'b1, 1'b0, 1'b0, 19, 1'b0};
        vt[2] = '{1, 4'b0010, 1'b1, 1'b0, 1'b0,  5, 1'b0};
        vt[3] = '{1, 4'b0100, 1'b0, 1'b1, 1'b0,  6, 1'b0};
        vt[4] = '{1, 4'b0010, 1'b0, 1'b0, 1'b0,  5, 1'b1};
        vt[5] = '{1, 4'b0101, 1'b1, 1'b0, 1'b0,  4, 1'b0};
        vt[6] = '{3, 4'b0100, 1'b1, 1'b0, 1'b1, 14, 1'b0};
        vt[7] = '{0, 4'b1110, 1'b0, 1'b0, 1'b0,  1, 1'b1};

        repeat (3) @(negedge clk);
        chk_reset_vals("por");
        rst = 1'b0;
        t0 = cyc; c0 = 0; m_ready = 0; m_over = 0; m_code = 0;

        for (int n = 2; n <= 22; n += 4) begin
            step_to(t0 + n);
            chk("idle_column_cycle", key_x, colpat((n / DIV) % 5));
        end
        step_to(t0 + 26);
        #2 rst = 1'b1;
        #1 chk_reset_vals("async_reset");
        @(negedge clk);
        rst = 1'b0;
        t0 = cyc; c0 = 0;

        for (int i = 0; i < 8; i++)
            do_key(vt[i].c, vt[i].mask, vt[i].rd_first, vt[i].rd_emit,
                   vt[i].glitch, 3 + i, vt[i].exp_code, vt[i].exp_over);

        // Bounce: low for exactly one sample, then high again.
        c = c0;
        pressed[c] = 4'b0100;
        s = first_sample(t0, c0, c, cyc);
        step_to(s);
        pressed[c] = 4'b0000;
        step_to(s + 1);
        chk("bounce_busy", key_busy, 1);
        step_to(s + DIV);
        chk("bounce_back_to_scan", key_busy, 0);
        chk("bounce_no_emit", key_ready, m_ready);
        chk("bounce_column_advance", key_x, colpat((c + 1) % 5));
        t0 = s + DIV; c0 = (c + 1) % 5;

        // Reset while debouncing; the still-held key must come out once.
        pressed[3] = 4'b0001;
        s = first_sample(t0, c0, 3, cyc);
        step_to(s + 1);
        chk("debounce_busy", key_busy, 1);
        #2 rst = 1'b1;
        #1 chk_reset_vals("debounce_reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        t0 = cyc; c0 = 0; m_ready = 0; m_over = 0; m_code = 0;
        do_key(3, 4'b0001, 1'b0, 1'b0, 1'b0, 20, 12, 1'b0);

        for (int i = 0; i < 12; i++) begin
            c    = int'($urandom_range(0, 4));
            mask = 4'($urandom_range(1, 15));
            rf   = 1'($urandom_range(0, 1));
            re   = ($urandom_range(0, 3) == 0);
            hold = int'($urandom_range(0, 12));
            rp   = rf ? 1'b0 : m_ready;
            op   = rf ? 1'b0 : m_over;
            exp_over = (re && rp) ? 1'b0 : (rp ? 1'b1 : op);
            exp_code = ref_code(c, mask);
            do_key(c, mask, rf, re, 1'b0, hold, exp_code, exp_over);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
